// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single fixed-latency memory port.
// One transaction at a time: IDLE -> BUSY (LATENCY cycles) -> RESP (one-cycle ack) -> IDLE.
module mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [63:0] if_data_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_mask_i,
    output logic        mem_ack_o,
    output logic [63:0] mem_data_o,
    output logic        ms_req_o,
    output logic [31:0] ms_addr_o,
    output logic        ms_write_o,
    output logic [31:0] ms_write_data_o,
    output logic [3:0]  ms_write_mask_o,
    input  logic [63:0] ms_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_MEM} grant_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    grant_t      last_grant, last_grant_next;
    grant_t      owner, owner_next;
    logic [31:0] lat_addr, lat_addr_next;
    logic [31:0] lat_wdata, lat_wdata_next;
    logic [3:0]  lat_mask, lat_mask_next;
    logic        lat_we, lat_we_next;
    logic        pick_mem;
    logic        resp_if, resp_mem;

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_grant_next = last_grant;
        owner_next      = owner;
        lat_addr_next   = lat_addr;
        lat_wdata_next  = lat_wdata;
        lat_mask_next   = lat_mask;
        lat_we_next     = lat_we;
        // On conflict, alternate away from whoever was served last
        pick_mem = mem_req_i && (!if_req_i || last_grant == GNT_IF);

        case (state)
            IDLE: begin
                if (if_req_i || mem_req_i) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                    if (pick_mem) begin
                        owner_next      = GNT_MEM;
                        last_grant_next = GNT_MEM;
                        lat_addr_next   = mem_addr_i;
                        lat_we_next     = mem_we_i;
                        lat_wdata_next  = mem_wdata_i;
                        lat_mask_next   = mem_mask_i;
                    end else begin
                        owner_next      = GNT_IF;
                        last_grant_next = GNT_IF;
                        lat_addr_next   = if_addr_i;
                        lat_we_next     = 1'b0;
                        lat_wdata_next  = '0;
                        lat_mask_next   = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign resp_if  = (state_next == RESP) && (owner_next == GNT_IF);
    assign resp_mem = (state_next == RESP) && (owner_next == GNT_MEM);

    // Outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            last_grant      <= GNT_IF;
            owner           <= GNT_IF;
            lat_addr        <= '0;
            lat_wdata       <= '0;
            lat_mask        <= '0;
            lat_we          <= 1'b0;
            ms_req_o        <= 1'b0;
            ms_addr_o       <= '0;
            ms_write_o      <= 1'b0;
            ms_write_data_o <= '0;
            ms_write_mask_o <= '0;
            busy_o          <= 1'b0;
            if_ack_o        <= 1'b0;
            if_data_o       <= '0;
            mem_ack_o       <= 1'b0;
            mem_data_o      <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_grant <= last_grant_next;
            owner      <= owner_next;
            lat_addr   <= lat_addr_next;
            lat_wdata  <= lat_wdata_next;
            lat_mask   <= lat_mask_next;
            lat_we     <= lat_we_next;

            ms_req_o        <= (state_next == BUSY);
            ms_addr_o       <= (state_next == BUSY) ? lat_addr_next  : '0;
            ms_write_data_o <= (state_next == BUSY) ? lat_wdata_next : '0;
            ms_write_mask_o <= (state_next == BUSY) ? lat_mask_next  : '0;
            ms_write_o      <= (state_next == BUSY) && (cnt_next == 4'd0) && lat_we_next;
            busy_o          <= (state_next != IDLE);

            if_ack_o   <= resp_if;
            if_data_o  <= resp_if ? ms_rdata_i : '0;
            mem_ack_o  <= resp_mem;
            mem_data_o <= (resp_mem && !lat_we_next) ? ms_rdata_i : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected acks/writes,
// negedge monitors pop and compare whenever the DUT strobes.
module tb_mem_arbiter;

    typedef struct {
        int          side;
        logic [63:0] data;
        int          cyc;
    } ack_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ack_t ack_q[$];
    wr_t  wr_q[$];
    ack_t b_ack_q[$];

    // LATENCY=2 instance
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [63:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_mask = '0;
    logic        mem_ack;
    logic [63:0] mem_data;
    logic        ms_req;
    logic [31:0] ms_addr;
    logic        ms_write;
    logic [31:0] ms_wdata;
    logic [3:0]  ms_mask;
    logic [63:0] ms_rdata = '0;
    logic        busy;

    // LATENCY=1 instance
    logic        b_if_req = 1'b0;
    logic [31:0] b_if_addr = '0;
    logic        b_if_ack;
    logic [63:0] b_if_data;
    logic        b_mem_ack;
    logic [63:0] b_mem_data;
    logic        b_ms_req;
    logic [31:0] b_ms_addr;
    logic        b_ms_write;
    logic [31:0] b_ms_wdata;
    logic [3:0]  b_ms_mask;
    logic [63:0] b_ms_rdata = '0;
    logic        b_busy;

    mem_arbiter #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_mask_i(mem_mask),
        .mem_ack_o(mem_ack), .mem_data_o(mem_data),
        .ms_req_o(ms_req), .ms_addr_o(ms_addr), .ms_write_o(ms_write),
        .ms_write_data_o(ms_wdata), .ms_write_mask_o(ms_mask),
        .ms_rdata_i(ms_rdata), .busy_o(busy)
    );

    mem_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack), .if_data_o(b_if_data),
        .mem_req_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(32'h0),
        .mem_wdata_i(32'h0), .mem_mask_i(4'h0),
        .mem_ack_o(b_mem_ack), .mem_data_o(b_mem_data),
        .ms_req_o(b_ms_req), .ms_addr_o(b_ms_addr), .ms_write_o(b_ms_write),
        .ms_write_data_o(b_ms_wdata), .ms_write_mask_o(b_ms_mask),
        .ms_rdata_i(b_ms_rdata), .busy_o(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor for the LATENCY=2 instance
    always @(negedge clk) begin
        ack_t e;
        wr_t  w;
        if (if_ack || mem_ack) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected @cyc %0d: if_ack=%b mem_ack=%b", cyc, if_ack, mem_ack);
            end else begin
                e = ack_q.pop_front();
                if ((if_ack && mem_ack) || (int'(mem_ack) != e.side) || (cyc != e.cyc) ||
                    ((mem_ack ? mem_data : if_data) !== e.data)) begin
                    errors++;
                    $display("FAIL ack @cyc %0d: side=%0d data=%h, expected side=%0d data=%h cyc=%0d",
                             cyc, int'(mem_ack), mem_ack ? mem_data : if_data, e.side, e.data, e.cyc);
                end
            end
        end
        if (!if_ack && if_data != 0) check("if_data_idle", if_data, 64'h0);
        if (!mem_ack && mem_data != 0) check("mem_data_idle", mem_data, 64'h0);
        if (ms_write) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected @cyc %0d: addr=%h data=%h", cyc, ms_addr, ms_wdata);
            end else begin
                w = wr_q.pop_front();
                if (cyc != w.cyc || ms_addr !== w.addr || ms_wdata !== w.data || ms_mask !== w.mask) begin
                    errors++;
                    $display("FAIL write @cyc %0d: addr=%h data=%h mask=%b, expected cyc=%0d addr=%h data=%h mask=%b",
                             cyc, ms_addr, ms_wdata, ms_mask, w.cyc, w.addr, w.data, w.mask);
                end
            end
        end
    end

    // Monitor for the LATENCY=1 instance
    always @(negedge clk) begin
        ack_t e;
        if (b_if_ack || b_mem_ack || b_ms_write) begin
            checks++;
            if (b_mem_ack || b_ms_write || b_ack_q.size() == 0) begin
                errors++;
                $display("FAIL b_strobe_unexpected @cyc %0d: if_ack=%b mem_ack=%b write=%b",
                         cyc, b_if_ack, b_mem_ack, b_ms_write);
            end else begin
                e = b_ack_q.pop_front();
                if (cyc != e.cyc || b_if_data !== e.data) begin
                    errors++;
                    $display("FAIL b_ack @cyc %0d: data=%h, expected cyc=%0d data=%h",
                             cyc, b_if_data, e.cyc, e.data);
                end
            end
        end
    end

    initial begin
        // Reset: all outputs low even with both requests asserted
        if_req   = 1'b1; if_addr  = 32'h0000_0040;
        mem_req  = 1'b1; mem_addr = 32'h0000_0080;
        ms_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        at_cycle(2);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_ms_req", {63'h0, ms_req}, 64'h0);
        check("rst_ms_addr", {32'h0, ms_addr}, 64'h0);
        check("rst_ms_write", {63'h0, ms_write}, 64'h0);
        check("rst_acks", {62'h0, if_ack, mem_ack}, 64'h0);
        check("rst_b_busy", {63'h0, b_busy}, 64'h0);

        // Both held from reset release: MEM, IF, MEM, IF
        at_cycle(3);
        rst = 1'b0;
        ack_q.push_back('{1, 64'hAAAA_BBBB_CCCC_DDDD, 6});
        ack_q.push_back('{0, 64'hAAAA_BBBB_CCCC_DDDD, 10});
        ack_q.push_back('{1, 64'hAAAA_BBBB_CCCC_DDDD, 14});
        ack_q.push_back('{0, 64'hAAAA_BBBB_CCCC_DDDD, 18});
        at_cycle(4);
        check("grant1_addr", {32'h0, ms_addr}, 64'h80);
        at_cycle(8);
        check("grant2_addr", {32'h0, ms_addr}, 64'h40);
        at_cycle(18);
        if_req = 1'b0; mem_req = 1'b0;

        // IF-only load
        at_cycle(20);
        if_req = 1'b1; if_addr = 32'h0000_0010; ms_rdata = 64'h1122_3344_5566_7788;
        ack_q.push_back('{0, 64'h1122_3344_5566_7788, 23});
        at_cycle(21);
        check("if_load_ms_req", {63'h0, ms_req}, 64'h1);
        check("if_load_ms_addr", {32'h0, ms_addr}, 64'h10);
        at_cycle(23);
        if_req = 1'b0;

        // Store
        at_cycle(25);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0104;
        mem_wdata = 32'h0000_0041; mem_mask = 4'b0001; ms_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        ack_q.push_back('{1, 64'h0, 28});
        wr_q.push_back('{27, 32'h0000_0104, 32'h0000_0041, 4'b0001});
        at_cycle(28);
        mem_req = 1'b0; mem_we = 1'b0;

        // Load with operands changed mid-transaction
        at_cycle(30);
        mem_req = 1'b1; mem_addr = 32'h0000_0200; ms_rdata = 64'h0123_4567_89AB_CDEF;
        ack_q.push_back('{1, 64'h0123_4567_89AB_CDEF, 33});
        at_cycle(31);
        mem_addr = 32'h0000_0300; mem_we = 1'b1;
        check("hold_addr_b1", {32'h0, ms_addr}, 64'h200);
        at_cycle(32);
        check("hold_addr_b2", {32'h0, ms_addr}, 64'h200);
        at_cycle(33);
        mem_req = 1'b0; mem_we = 1'b0;

        // Reset during a store: no write, no ack, then normal restart
        at_cycle(36);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0108;
        mem_wdata = 32'h0000_0055; mem_mask = 4'hF;
        at_cycle(37);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        at_cycle(38);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_ms", {30'h0, ms_req, ms_write, ms_addr}, 64'h0);
        check("abort_acks", {62'h0, if_ack, mem_ack}, 64'h0);
        at_cycle(39);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0020; ms_rdata = 64'h0F0E_0D0C_0B0A_0908;
        ack_q.push_back('{0, 64'h0F0E_0D0C_0B0A_0908, 42});
        at_cycle(42);
        if_req = 1'b0;

        // LATENCY=1 back-to-back fetches
        at_cycle(45);
        b_if_req = 1'b1; b_if_addr = 32'h0000_0030; b_ms_rdata = 64'h5555_AAAA_5555_AAAA;
        b_ack_q.push_back('{0, 64'h5555_AAAA_5555_AAAA, 47});
        b_ack_q.push_back('{0, 64'h5555_AAAA_5555_AAAA, 50});
        b_ack_q.push_back('{0, 64'h5555_AAAA_5555_AAAA, 53});
        for (int k = 46; k <= 53; k++) begin
            at_cycle(k);
            check($sformatf("b_busy_%0d", k), {63'h0, b_busy}, {63'h0, ((k - 45) % 3) != 0});
        end
        b_if_req = 1'b0;

        at_cycle(60);
        check("ack_q_drained", 64'(ack_q.size()), 64'h0);
        check("wr_q_drained", 64'(wr_q.size()), 64'h0);
        check("b_ack_q_drained", 64'(b_ack_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
